// File: rtl/ascii_dec_parser.sv
// Purpose: accumulate an ASCII decimal number from UART rx bytes, deliver it on CR/LF.
// Latency: value_valid/err pulse one cycle after the terminator byte is strobed.
// Backpressure: none; one byte per cycle is always accepted, so the source never stalls.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   rx_data, rx_valid  byte from the UART receiver, valid for one cycle
//   value, digit_count last good number and its digit count, held between good frames
//   value_valid, err   one-cycle pulses: new value / frame discarded
//   busy               a frame is in progress
//   echo_data, echo_valid  (ASCDEC_ECHO_EN only) every consumed byte, one cycle late
//
// Optional build macro: ASCDEC_ECHO_EN adds the echo loop-back outputs.

module ascii_dec_parser #(
    parameter int MAX_DIGITS = 4,
    parameter int VAL_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [VAL_W-1:0] value,
    output logic             value_valid,
    output logic [3:0]       digit_count,
    output logic             err,
`ifdef ASCDEC_ECHO_EN
    output logic [7:0]       echo_data,
    output logic             echo_valid,
`endif
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

    logic [1:0]       state, state_nxt;
    logic [VAL_W-1:0] acc, acc_nxt;
    logic [3:0]       digits, digits_nxt;
    logic             good_frame;
    logic             bad_frame;

    // Byte classification
    logic             is_digit;
    logic             is_term;
    logic [VAL_W-1:0] digit_ext;
    logic [VAL_W-1:0] acc_x10;

    assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    // For '0'..'9' the low nibble is the digit value directly.
    assign digit_ext = VAL_W'(rx_data[3:0]);
    // acc*10 as shift-add; VAL_W is sized so this never overflows within MAX_DIGITS.
    assign acc_x10   = (acc << 3) + (acc << 1);

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        digits_nxt = digits;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (is_digit) begin
                        acc_nxt    = digit_ext;
                        digits_nxt = 4'd1;
                        state_nxt  = S_ACCUM;
                    end else if (!is_term) begin
                        state_nxt  = S_ERR;
                    end
                    // Stray terminators (CR/LF pairs, blank lines) are ignored.
                end
                S_ACCUM: begin
                    if (is_digit) begin
                        if (digits == MAX_D) begin
                            state_nxt = S_ERR;
                        end else begin
                            acc_nxt    = acc_x10 + digit_ext;
                            digits_nxt = digits + 4'd1;
                        end
                    end else if (is_term) begin
                        good_frame = 1'b1;
                        acc_nxt    = '0;
                        digits_nxt = 4'd0;
                        state_nxt  = S_IDLE;
                    end else begin
                        state_nxt  = S_ERR;
                    end
                end
                S_ERR: begin
                    // Swallow everything until the frame ends, then flag it once.
                    if (is_term) begin
                        bad_frame  = 1'b1;
                        acc_nxt    = '0;
                        digits_nxt = 4'd0;
                        state_nxt  = S_IDLE;
                    end
                end
                default: begin
                    state_nxt  = S_IDLE;
                    acc_nxt    = '0;
                    digits_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            digits      <= 4'd0;
            value       <= '0;
            digit_count <= 4'd0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            digits      <= digits_nxt;
            value_valid <= good_frame;
            err         <= bad_frame;
            // Outputs only move on a good frame; error frames leave them intact.
            if (good_frame) begin
                value       <= acc;
                digit_count <= digits;
            end
        end
    end

    assign busy = (state != S_IDLE);

`ifdef ASCDEC_ECHO_EN
    // Loop-back path is independent of parser state: every consumed byte echoes.
    always_ff @(posedge clk) begin
        if (rst) begin
            echo_data  <= 8'h00;
            echo_valid <= 1'b0;
        end else begin
            echo_valid <= rx_valid;
            if (rx_valid) begin
                echo_data <= rx_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ascii_dec_parser.sv
module tb_ascii_dec_parser;

    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [13:0] value;
    logic        value_valid;
    logic [3:0]  digit_count;
    logic        err;
    logic        busy;
`ifdef ASCDEC_ECHO_EN
    logic [7:0]  echo_data;
    logic        echo_valid;
`endif

    ascii_dec_parser #(.MAX_DIGITS(MAXD), .VAL_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .value       (value),
        .value_valid (value_valid),
        .digit_count (digit_count),
        .err         (err),
`ifdef ASCDEC_ECHO_EN
        .echo_data   (echo_data),
        .echo_valid  (echo_valid),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bytes of the current frame, last delivered value/count.
    logic [7:0] cur[$];
    int         m_value = 0;
    int         m_count = 0;
    bit         exp_vv;
    bit         exp_err;
    bit         exp_echo_v;
    logic [7:0] exp_echo_d;
    logic [20:0] obs;
    logic [20:0] expv;

    function automatic bit is_dig(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic bit is_trm(input logic [7:0] b);
        return (b == 8'h0D) || (b == 8'h0A);
    endfunction

    // A frame is everything between terminators; it is good only if it is
    // 1..MAXD bytes long and every byte is a digit.
    function automatic void model_step(input logic [7:0] b);
        bit ok;
        int n;
        if (is_trm(b)) begin
            if (cur.size() != 0) begin
                ok = (cur.size() <= MAXD);
                foreach (cur[i]) if (!is_dig(cur[i])) ok = 0;
                if (ok) begin
                    n = 0;
                    foreach (cur[i]) n = n * 10 + (int'(cur[i]) - 48);
                    m_value = n;
                    m_count = cur.size();
                    exp_vv  = 1;
                end else begin
                    exp_err = 1;
                end
                cur.delete();
            end
        end else begin
            cur.push_back(b);
        end
    endfunction

    function automatic logic [20:0] model_obs();
        return {exp_vv, exp_err, (cur.size() != 0), 4'(m_count), 14'(m_value)};
    endfunction

    task automatic model_reset();
        cur.delete();
        m_value = 0;
        m_count = 0;
        exp_vv  = 0;
        exp_err = 0;
        exp_echo_v = 0;
    endtask

    // One cycle of stimulus; outputs are sampled 1ns after the active edge.
    task automatic drive(input logic [7:0] b, input bit v);
        rx_data  = b;
        rx_valid = v;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        exp_vv   = 0;
        exp_err  = 0;
        if (v) model_step(b);
        exp_echo_v = v;
        if (v) exp_echo_d = b;
        obs  = {value_valid, err, busy, digit_count, value};
        expv = model_obs();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        obs = {value_valid, err, busy, digit_count, value};
        checks++;
        if (obs !== 21'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, 21'h0);
        end
`ifdef ASCDEC_ECHO_EN
        checks++;
        if (echo_valid !== 1'b0 || echo_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_echo got=%b/%h exp=0/00", echo_valid, echo_data);
        end
`endif
    endtask

    task automatic test_directed();
        logic [7:0] s[$];
        s = {8'h31, 8'h32, 8'h33, 8'h0D,                 // 123
             8'h39, 8'h39, 8'h39, 8'h39, 8'h0A, 8'h0D,   // 9999, then stray CR
             8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D,   // too long
             8'h34, 8'h78, 8'h32, 8'h0D,                 // bad char
             8'h37, 8'h0D,                               // 7
             8'h30, 8'h30, 8'h30, 8'h37, 8'h0A,          // leading zeros
             8'h0D, 8'h0A, 8'h0D};                       // blank lines
        foreach (s[i]) begin
            drive(s[i], 1'b1);
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL directed idx=%0d byte=%h got=%h exp=%h", i, s[i], obs, expv);
            end
        end
        drive(8'h00, 1'b0);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL directed_idle got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic test_mid_frame_reset();
        drive(8'h35, 1'b1);
        drive(8'h36, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid_frame got=%b exp=1", busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        obs = {value_valid, err, busy, digit_count, value};
        checks++;
        if (obs !== model_obs()) begin
            failures++;
            $display("FAIL mid_reset_state got=%h exp=%h", obs, model_obs());
        end
        drive(8'h38, 1'b1);
        drive(8'h0D, 1'b1);
        checks++;
        if (obs !== expv || expv[20] !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_frame got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic test_echo();
`ifdef ASCDEC_ECHO_EN
        logic [7:0] s[$];
        s = {8'h41, 8'h33, 8'h0D};
        foreach (s[i]) begin
            drive(s[i], 1'b1);
            checks++;
            if (echo_valid !== 1'b1 || echo_data !== s[i] || obs !== expv) begin
                failures++;
                $display("FAIL echo idx=%0d got=%b/%h obs=%h exp=1/%h obs=%h",
                         i, echo_valid, echo_data, obs, s[i], expv);
            end
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL echo_err got=%b exp=1", err);
        end
        drive(8'h55, 1'b0);
        checks++;
        if (echo_valid !== 1'b0) begin
            failures++;
            $display("FAIL echo_idle got=%b exp=0", echo_valid);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] fr[$];
        logic [7:0] b;
        int len;
        for (int f = 0; f < 400; f++) begin
            fr.delete();
            len = $urandom_range(0, 6);
            for (int k = 0; k < len; k++) fr.push_back(8'(8'h30 + $urandom_range(0, 9)));
            if (len != 0 && $urandom_range(0, 7) == 0) begin
                do b = 8'($urandom_range(0, 255)); while (is_dig(b) || is_trm(b));
                fr[$urandom_range(0, len - 1)] = b;
            end
            fr.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
            if ($urandom_range(0, 5) == 0) fr.push_back(8'h0A);
            foreach (fr[i]) begin
                if ($urandom_range(0, 9) < 3) begin
                    drive(8'($urandom_range(0, 255)), 1'b0);
                    checks++;
                    if (obs !== expv) begin
                        failures++;
                        $display("FAIL random_gap frame=%0d got=%h exp=%h", f, obs, expv);
                    end
                end
                drive(fr[i], 1'b1);
                checks++;
                if (obs !== expv) begin
                    failures++;
                    $display("FAIL random frame=%0d byte=%h got=%h exp=%h", f, fr[i], obs, expv);
                end
`ifdef ASCDEC_ECHO_EN
                checks++;
                if (echo_valid !== 1'b1 || echo_data !== exp_echo_d) begin
                    failures++;
                    $display("FAIL random_echo frame=%0d got=%b/%h exp=1/%h",
                             f, echo_valid, echo_data, exp_echo_d);
                end
`endif
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_directed();
        test_mid_frame_reset();
        test_echo();
        test_random();
        test_directed();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
